// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcode values,
// FSM state encoding, datapath mux select codes and the decoded
// instruction-class bundle. Used by the control FSM, the datapath and the bench.
package ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_U    = 3'b100,
    IMM_J    = 3'b101
  } imm_sel_t;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_CMP   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MEM    = 2'b01,
    RES_PC     = 2'b10
  } result_src_t;

  // One-hot instruction class
  typedef struct packed {
    logic r;
    logic i_alu;
    logic load;
    logic store;
    logic jalr;
    logic lui;
    logic auipc;
    logic branch;
    logic jal;
    logic sys;
  } op_class_t;

endpackage

// File: rtl/ctrl_opclass_dec.sv
// Combinational opcode classifier.
// Ports:
//   op, funct3, imm : instruction fields from the IR
//   cls             : one-hot instruction class
//   imm_sel         : immediate format select for the datapath
//   halt            : ECALL/EBREAK seen and halting on them is enabled
//   illegal         : opcode is not an RV32I opcode handled by this core
module ctrl_opclass_dec
  import ctrl_pkg::*;
#(
  parameter int unsigned HALT_ON_EBREAK = 1
) (
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [11:0] imm,
  output op_class_t   cls,
  output logic [2:0]  imm_sel,
  output logic        halt,
  output logic        illegal
);

  always_comb begin
    cls     = '0;
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    case (op)
      OP_REG:    cls.r = 1'b1;
      OP_IMM:    begin cls.i_alu  = 1'b1; imm_sel = IMM_I; end
      OP_LOAD:   begin cls.load   = 1'b1; imm_sel = IMM_I; end
      OP_STORE:  begin cls.store  = 1'b1; imm_sel = IMM_S; end
      OP_JALR:   begin cls.jalr   = 1'b1; imm_sel = IMM_I; end
      OP_LUI:    begin cls.lui    = 1'b1; imm_sel = IMM_U; end
      OP_AUIPC:  begin cls.auipc  = 1'b1; imm_sel = IMM_U; end
      OP_BRANCH: begin cls.branch = 1'b1; imm_sel = IMM_B; end
      OP_JAL:    begin cls.jal    = 1'b1; imm_sel = IMM_J; end
      OP_SYSTEM: cls.sys = 1'b1;
      default:   illegal = 1'b1;
    endcase
    halt = (HALT_ON_EBREAK != 0) && (op == OP_SYSTEM) && (funct3 == 3'b000) &&
           ((imm == 12'h000) || (imm == 12'h001));
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// one shared ALU and one memory port, with a memory watchdog and a
// retired-instruction counter.
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   op, funct3, imm           : IR fields
//   mem_ready, branch_taken   : memory handshake completion, ALU compare result
//   mem_req, mem_we, addr_sel : memory port control
//   ir_we, pc_we, pc_src      : IR/OldPC and PC write control
//   reg_we, result_src        : register-file write control
//   alu_src_a/b, alu_op       : shared-ALU operand and operation selects
//   imm_sel                   : immediate format (decoded from op in every state)
//   halted, err, instret      : status (sticky halt, error flags, retire count)
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYC    = 255,
  parameter int unsigned HALT_ON_EBREAK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [11:0]      imm,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_sel,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [31:0] WD_LAST = TIMEOUT_CYC - 32'd1;

  state_t           state, state_next;
  op_class_t        cls;
  logic [2:0]       dec_imm_sel;
  logic             dec_halt, dec_illegal;
  logic [31:0]      wd_cnt;
  logic             waiting, wd_trip, retire;
  logic [1:0]       err_q;
  logic [CNT_W-1:0] cnt_q;

  ctrl_opclass_dec #(.HALT_ON_EBREAK(HALT_ON_EBREAK)) u_dec (
    .op      (op),
    .funct3  (funct3),
    .imm     (imm),
    .cls     (cls),
    .imm_sel (dec_imm_sel),
    .halt    (dec_halt),
    .illegal (dec_illegal)
  );

  // Derived from state rather than mem_req so the watchdog does not feed back
  // into the output/next-state process.
  assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
  // Trips on the TIMEOUT_CYC-th consecutive wait cycle, so mem_req is high for
  // exactly TIMEOUT_CYC unanswered cycles and is gone the cycle after.
  assign wd_trip = (TIMEOUT_CYC != 0) && waiting && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      wd_cnt <= '0;
      err_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_next;
      wd_cnt <= (waiting && !wd_trip) ? wd_cnt + 32'd1 : '0;
      if (state == ST_DECODE && dec_illegal) err_q[0] <= 1'b1;
      if (wd_trip)                           err_q[1] <= 1'b1;
      if (retire)                            cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Outputs are held at zero for the whole time rst_n is low, so a reset
  // asserted mid-handshake withdraws mem_req immediately.
  assign err     = rst_n ? err_q : '0;
  assign instret = rst_n ? cnt_q : '0;

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    imm_sel    = dec_imm_sel;
    halted     = (state == ST_HALTED);

    case (state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = ST_DECODE;
        end else if (wd_trip) begin
          state_next = ST_HALTED;
        end
      end

      ST_DECODE: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_IMM;
        state_next = (dec_illegal || dec_halt) ? ST_HALTED : ST_EXEC;
      end

      ST_EXEC: begin
        state_next = ST_WB;
        if (cls.r) begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_FUNCT;
        end else if (cls.i_alu) begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_FUNCT;
        end else if (cls.load || cls.store) begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          state_next = ST_MEM;
        end else if (cls.jalr) begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end else if (cls.lui) begin
          alu_src_b = SRC_B_IMM;
        end else if (cls.auipc) begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
        end else if (cls.branch) begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_op     = ALU_CMP;
          pc_we      = branch_taken;
          pc_src     = branch_taken;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (cls.jal) begin
          pc_we      = 1'b1;
          pc_src     = 1'b1;
          reg_we     = 1'b1;
          result_src = RES_PC;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (cls.sys) begin
          // Non-halting SYSTEM instructions retire as NOPs.
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_HALTED;
        end
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = cls.store;
        if (mem_ready) begin
          if (cls.store) begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (wd_trip) begin
          state_next = ST_HALTED;
        end
      end

      ST_WB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
        if (cls.load) begin
          result_src = RES_MEM;
        end else if (cls.jalr) begin
          result_src = RES_PC;
          pc_we      = 1'b1;
          pc_src     = 1'b1;
        end
      end

      ST_HALTED: state_next = ST_HALTED;

      default: state_next = ST_FETCH;
    endcase

    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      reg_we     = 1'b0;
      alu_src_a  = '0;
      alu_src_b  = '0;
      alu_op     = '0;
      result_src = '0;
      imm_sel    = '0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each instruction is described
// as its sequence of cycles (fetch waits, decode, execute, memory waits,
// write-back) and the expected control outputs are built per cycle from the
// instruction class; retire count and sticky status are tracked alongside.
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic [11:0]      imm;
  logic             mem_ready, branch_taken;
  logic             mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we;
  logic [1:0]       alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0]       imm_sel;
  logic             halted;
  logic [1:0]       err;
  logic [CNT_W-1:0] instret;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we;
    logic [1:0] a, b, aop, res;
    logic [2:0] isel;
    logic       halted;
    logic [1:0] err;
  } outs_t;

  outs_t            act;
  logic [CNT_W-1:0] exp_cnt;
  logic             m_halted;
  logic [1:0]       m_err;
  int               n_tests = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               ms_cnt = 0;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT_CYC(4), .HALT_ON_EBREAK(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .imm(imm),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .imm_sel(imm_sel), .halted(halted), .err(err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we,
                alu_src_a, alu_src_b, alu_op, result_src, imm_sel, halted, err};

  function automatic logic [2:0] isel_of(input logic [6:0] o);
    case (o)
      OP_IMM, OP_LOAD, OP_JALR: return 3'b001;
      OP_STORE:                 return 3'b010;
      OP_BRANCH:                return 3'b011;
      OP_LUI, OP_AUIPC:         return 3'b100;
      OP_JAL:                   return 3'b101;
      default:                  return 3'b000;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                     OP_STORE, OP_IMM, OP_REG, OP_SYSTEM};
  endfunction

  // Quiet cycle: no enables, only the always-decoded immediate and status.
  function automatic outs_t idle();
    outs_t e;
    e        = '0;
    e.isel   = isel_of(op);
    e.halted = m_halted;
    e.err    = m_err;
    return e;
  endfunction

  // One clock cycle: drive inputs, compare mid-cycle, advance past the edge.
  task automatic step(input logic rdy, input logic tk, input outs_t e, input string tag);
    mem_ready    = rdy;
    branch_taken = tk;
    @(negedge clk);
    cyc++;
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s cyc%0d outs: got %h exp %h", tag, cyc, act, e);
    end
    n_tests++;
    if (instret !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s cyc%0d instret: got %0d exp %0d", tag, cyc, instret, exp_cnt);
    end
    if (act.mem_req && act.addr_sel) ms_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", name, got, want);
    end
  endtask

  task automatic do_reset(input string tag);
    outs_t z;
    z        = '0;
    exp_cnt  = '0;
    m_halted = 1'b0;
    m_err    = '0;
    rst_n    = 1'b0;
    step(1'b1, 1'b0, z, tag);
    step(1'b0, 1'b0, z, tag);
    rst_n = 1'b1;
  endtask

  task automatic halt_cycles(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b1, idle(), tag);
  endtask

  // fw/mw: wait cycles before mem_ready in fetch/memory; noise drives
  // mem_ready high in cycles where it must be ignored; abort_mem stops
  // before the memory access is answered.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic [11:0] im, input int unsigned fw, input int unsigned mw,
                           input logic tk, input logic noise, input logic abort_mem);
    outs_t e;
    op = o; funct3 = f3; imm = im;
    for (int unsigned i = 0; i <= fw; i++) begin
      e = idle(); e.mem_req = 1'b1; e.b = 2'b10;
      if (i == fw) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
      step(i == fw, 1'b0, e, tag);
    end
    e = idle(); e.a = 2'b01; e.b = 2'b01;
    step(noise, 1'b0, e, tag);
    if (!is_legal(o)) begin m_err[0] = 1'b1; m_halted = 1'b1; return; end
    if (o == OP_SYSTEM && f3 == 3'b000 && (im == 12'h000 || im == 12'h001)) begin
      m_halted = 1'b1;
      return;
    end
    e = idle();
    case (o)
      OP_REG:                    begin e.a = 2'b10; e.aop = 2'b10; end
      OP_IMM:                    begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
      OP_LOAD, OP_STORE, OP_JALR: begin e.a = 2'b10; e.b = 2'b01; end
      OP_LUI:                    e.b = 2'b01;
      OP_AUIPC:                  begin e.a = 2'b01; e.b = 2'b01; end
      OP_BRANCH:                 begin e.a = 2'b10; e.aop = 2'b01; e.pc_we = tk; e.pc_src = tk; end
      OP_JAL:                    begin e.pc_we = 1'b1; e.pc_src = 1'b1; e.reg_we = 1'b1; e.res = 2'b10; end
      default: ;
    endcase
    step(noise, tk, e, tag);
    if (o inside {OP_BRANCH, OP_JAL, OP_SYSTEM}) begin exp_cnt++; return; end
    if (o inside {OP_LOAD, OP_STORE}) begin
      for (int unsigned i = 0; i <= mw; i++) begin
        if (abort_mem && i == mw) return;
        e = idle(); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (o == OP_STORE);
        step(i == mw, 1'b0, e, tag);
      end
      if (o == OP_STORE) begin exp_cnt++; return; end
    end
    e = idle(); e.reg_we = 1'b1;
    if (o == OP_LOAD) e.res = 2'b01;
    if (o == OP_JALR) begin e.res = 2'b10; e.pc_we = 1'b1; e.pc_src = 1'b1; end
    step(noise, 1'b0, e, tag);
    exp_cnt++;
  endtask

  initial begin
    outs_t e;
    op = OP_IMM; funct3 = '0; imm = '0; mem_ready = 1'b0; branch_taken = 1'b0;
    exp_cnt = '0; m_halted = 1'b0; m_err = '0;

    do_reset("reset");
    check_lit("rst_instret", 32'(instret), 32'd0);
    check_lit("rst_err", 32'(err), 32'd0);

    run_instr("addi", OP_IMM, 3'b000, 12'd5, 0, 0, 1'b0, 1'b1, 1'b0);
    check_lit("addi_instret", 32'(instret), 32'd1);
    ms_cnt = 0;
    run_instr("lw", OP_LOAD, 3'b010, 12'd8, 3, 3, 1'b0, 1'b0, 1'b0);
    check_lit("lw_mem_cycles", 32'(ms_cnt), 32'd4);
    run_instr("sw", OP_STORE, 3'b010, 12'd4, 0, 1, 1'b0, 1'b1, 1'b0);
    run_instr("beq_taken", OP_BRANCH, 3'b000, 12'h010, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr("beq_not_taken", OP_BRANCH, 3'b000, 12'h010, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr("jal", OP_JAL, 3'b000, 12'h020, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("jalr", OP_JALR, 3'b000, 12'h004, 1, 0, 1'b0, 1'b1, 1'b0);
    run_instr("lui", OP_LUI, 3'b000, 12'h123, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("auipc", OP_AUIPC, 3'b000, 12'h001, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("add", OP_REG, 3'b000, 12'h000, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr("csrrw_nop", OP_SYSTEM, 3'b001, 12'h300, 0, 0, 1'b0, 1'b0, 1'b0);
    check_lit("instret_11", 32'(instret), 32'd11);

    run_instr("illegal", 7'b1111111, 3'b000, 12'h000, 0, 0, 1'b0, 1'b0, 1'b0);
    halt_cycles(3, "illegal_halted");
    check_lit("illegal_err", 32'(err), 32'd1);
    check_lit("illegal_halted", 32'(halted), 32'd1);
    do_reset("reset_after_illegal");
    check_lit("rst_clears_err", 32'(err), 32'd0);
    check_lit("rst_clears_halt", 32'(halted), 32'd0);

    run_instr("ebreak", OP_SYSTEM, 3'b000, 12'h001, 0, 0, 1'b0, 1'b0, 1'b0);
    halt_cycles(2, "ebreak_halted");
    check_lit("ebreak_halted", 32'(halted), 32'd1);
    check_lit("ebreak_err", 32'(err), 32'd0);
    do_reset("reset_after_ebreak");

    op = OP_IMM; funct3 = '0; imm = '0;
    for (int i = 0; i < 4; i++) begin
      e = idle(); e.mem_req = 1'b1; e.b = 2'b10;
      step(1'b0, 1'b0, e, "timeout_wait");
    end
    m_err[1] = 1'b1; m_halted = 1'b1;
    halt_cycles(2, "timeout_halted");
    check_lit("timeout_err", 32'(err), 32'd2);
    check_lit("timeout_mem_req", 32'(mem_req), 32'd0);
    do_reset("reset_after_timeout");

    run_instr("lw_abort", OP_LOAD, 3'b010, 12'h000, 0, 2, 1'b0, 1'b0, 1'b1);
    do_reset("reset_mid_mem");

    for (int i = 0; i < 15; i++) run_instr("nop", OP_IMM, 3'b000, 12'h000, 0, 0, 1'b0, 1'b0, 1'b0);
    check_lit("instret_15", 32'(instret), 32'd15);
    run_instr("nop_wrap", OP_IMM, 3'b000, 12'h000, 0, 0, 1'b0, 1'b0, 1'b0);
    check_lit("instret_wrap", 32'(instret), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
